// File: rtl/hls_run_controller_if.sv
// Signal bundle between the run controller, its host and the Bambu-generated DUT.
// Optional feature macro: HLS_RUN_STATS_EN adds min_cycles/max_cycles/total_cycles.
// slave = controller side, master = host/DUT side.
interface hls_run_controller_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned RUN_W   = 16
`ifdef HLS_RUN_STATS_EN
    ,
    parameter int unsigned TOTAL_W = 48
`endif
) ();
    logic             go;
    logic [RUN_W-1:0] run_count;
    logic [CNT_W-1:0] timeout_cycles;
    logic             dut_reset;
    logic             dut_start_port;
    logic             dut_done_port;
    logic             busy;
    logic             run_valid;
    logic [RUN_W-1:0] run_index;
    logic [CNT_W-1:0] run_cycles;
    logic [1:0]       run_status;
    logic             campaign_done;
    logic             campaign_err;
`ifdef HLS_RUN_STATS_EN
    logic [CNT_W-1:0]   min_cycles;
    logic [CNT_W-1:0]   max_cycles;
    logic [TOTAL_W-1:0] total_cycles;

    modport slave (
        input  go, run_count, timeout_cycles, dut_done_port,
        output dut_reset, dut_start_port, busy, run_valid, run_index, run_cycles,
        output run_status, campaign_done, campaign_err, min_cycles, max_cycles, total_cycles
    );
    modport master (
        output go, run_count, timeout_cycles, dut_done_port,
        input  dut_reset, dut_start_port, busy, run_valid, run_index, run_cycles,
        input  run_status, campaign_done, campaign_err, min_cycles, max_cycles, total_cycles
    );
`else
    modport slave (
        input  go, run_count, timeout_cycles, dut_done_port,
        output dut_reset, dut_start_port, busy, run_valid, run_index, run_cycles,
        output run_status, campaign_done, campaign_err
    );
    modport master (
        output go, run_count, timeout_cycles, dut_done_port,
        input  dut_reset, dut_start_port, busy, run_valid, run_index, run_cycles,
        input  run_status, campaign_done, campaign_err
    );
`endif
endinterface

// File: rtl/hls_run_controller.sv
// Run sequencer for Bambu-generated tops: holds the DUT in reset, pulses start_port, measures
// done latency, repeats for run_count runs with an optional per-run timeout watchdog.
// Optional feature macro: HLS_RUN_STATS_EN adds min/max/total latency statistics over passes.
module hls_run_controller #(
    parameter int unsigned CNT_W            = 32,
    parameter int unsigned RUN_W            = 16,
    parameter int unsigned DUT_RESET_CYCLES = 2
`ifdef HLS_RUN_STATS_EN
    ,
    parameter int unsigned TOTAL_W          = 48
`endif
) (
    input logic                  i_clock,
    input logic                  i_reset,
    hls_run_controller_if.slave  bus
);
    localparam int unsigned DRST_W = (DUT_RESET_CYCLES > 1) ? $clog2(DUT_RESET_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StDrst, StStart, StWait, StReport, StFin} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [RUN_W-1:0] r_run_count;
    logic [CNT_W-1:0] r_timeout;
    logic [RUN_W-1:0] r_idx;
    // Inclusive cycle count (start cycle counts as 1) of the current WAIT cycle.
    logic [CNT_W-1:0] r_cnt;
    logic [DRST_W-1:0] r_drst_cnt;
    logic [RUN_W-1:0] r_run_index;
    logic [CNT_W-1:0] r_run_cycles;
    logic [1:0]       r_run_status;
    logic             r_err;

    logic             w_go_accept;
    logic             w_cap;
    logic             w_cap_to;
    logic [CNT_W-1:0] w_cap_cycles;
    logic [RUN_W:0]   w_idx_next;

    assign w_go_accept = (r_state == StIdle) && bus.go;
    assign w_idx_next  = {1'b0, r_idx} + (RUN_W+1)'(1);

    // Next-state decode and capture of the finished run's result.
    always_comb begin
        w_state_d    = r_state;
        w_cap        = 1'b0;
        w_cap_to     = 1'b0;
        w_cap_cycles = '0;
        unique case (r_state)
            StIdle: begin
                if (bus.go) begin
                    w_state_d = (bus.run_count == '0) ? StFin : StDrst;
                end
            end
            StDrst: begin
                if (r_drst_cnt == DRST_W'(DUT_RESET_CYCLES - 1)) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (bus.dut_done_port) begin
                    w_cap        = 1'b1;
                    w_cap_cycles = CNT_W'(1);
                    w_state_d    = StReport;
                end else begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                // Done takes priority over a coincident timeout.
                if (bus.dut_done_port) begin
                    w_cap        = 1'b1;
                    w_cap_cycles = r_cnt;
                    w_state_d    = StReport;
                end else if (r_timeout != '0 && r_cnt == r_timeout) begin
                    w_cap        = 1'b1;
                    w_cap_to     = 1'b1;
                    w_cap_cycles = r_timeout;
                    w_state_d    = StReport;
                end
            end
            StReport: begin
                if (r_run_status == 2'b00 && w_idx_next < {1'b0, r_run_count}) begin
                    w_state_d = StDrst;
                end else begin
                    w_state_d = StFin;
                end
            end
            StFin:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

`ifdef HLS_RUN_STATS_EN
    logic [CNT_W-1:0]   r_min;
    logic [CNT_W-1:0]   r_max;
    logic [TOTAL_W-1:0] r_total;
    logic [TOTAL_W:0]   w_sum;
    logic [TOTAL_W-1:0] w_total_sat;

    assign w_sum       = {1'b0, r_total} + (TOTAL_W+1)'(w_cap_cycles);
    assign w_total_sat = w_sum[TOTAL_W] ? '1 : w_sum[TOTAL_W-1:0];

    // Latency statistics over passing runs; cleared when a campaign is accepted.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_min   <= '0;
            r_max   <= '0;
            r_total <= '0;
        end else if (w_go_accept) begin
            r_min   <= '1;
            r_max   <= '0;
            r_total <= '0;
        end else if (w_cap && !w_cap_to) begin
            if (w_cap_cycles < r_min) r_min <= w_cap_cycles;
            if (w_cap_cycles > r_max) r_max <= w_cap_cycles;
            r_total <= w_total_sat;
        end
    end

    assign bus.min_cycles   = r_min;
    assign bus.max_cycles   = r_max;
    assign bus.total_cycles = r_total;
`endif

    // State register, campaign latches, cycle counter and held run results.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_run_count  <= '0;
            r_timeout    <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_drst_cnt   <= '0;
            r_run_index  <= '0;
            r_run_cycles <= '0;
            r_run_status <= 2'b00;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_go_accept) begin
                r_run_count <= bus.run_count;
                r_timeout   <= bus.timeout_cycles;
                r_idx       <= '0;
                r_err       <= 1'b0;
            end
            if (r_state == StDrst) begin
                r_drst_cnt <= r_drst_cnt + DRST_W'(1);
            end else begin
                r_drst_cnt <= '0;
            end
            // START is count 1, so the first WAIT cycle is count 2; saturate at all-ones.
            if (r_state == StStart) begin
                r_cnt <= CNT_W'(2);
            end else if (r_state == StWait && r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_cap) begin
                r_run_index  <= r_idx;
                r_run_cycles <= w_cap_cycles;
                r_run_status <= {1'b0, w_cap_to};
                r_err        <= w_cap_to;
            end
            if (r_state == StReport && w_state_d == StDrst) begin
                r_idx <= w_idx_next[RUN_W-1:0];
            end
        end
    end

    assign bus.dut_reset      = (r_state == StStart) || (r_state == StWait);
    assign bus.dut_start_port = (r_state == StStart);
    assign bus.busy           = (r_state != StIdle);
    assign bus.run_valid      = (r_state == StReport);
    assign bus.run_index      = r_run_index;
    assign bus.run_cycles     = r_run_cycles;
    assign bus.run_status     = r_run_status;
    assign bus.campaign_done  = (r_state == StFin);
    assign bus.campaign_err   = (r_state == StFin) && r_err;
endmodule

// File: tb/tb_hls_run_controller.sv
// Bench for hls_run_controller: each campaign is planned as a per-cycle timeline of expected
// outputs, computed from run latencies; the DUT's done pulses are replayed from that plan.
module tb_hls_run_controller;
    localparam int CNT_W   = 32;
    localparam int RUN_W   = 16;
    localparam int DRC     = 2;
    localparam int TOTAL_W = 48;
    localparam int MAXC    = 12000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   failures = 0;

`ifdef HLS_RUN_STATS_EN
    hls_run_controller_if #(.CNT_W(CNT_W), .RUN_W(RUN_W), .TOTAL_W(TOTAL_W)) bus ();
    hls_run_controller #(.CNT_W(CNT_W), .RUN_W(RUN_W), .DUT_RESET_CYCLES(DRC),
                         .TOTAL_W(TOTAL_W)) dut (.i_clock(clock), .i_reset(reset), .bus(bus));
`else
    hls_run_controller_if #(.CNT_W(CNT_W), .RUN_W(RUN_W)) bus ();
    hls_run_controller #(.CNT_W(CNT_W), .RUN_W(RUN_W), .DUT_RESET_CYCLES(DRC))
        dut (.i_clock(clock), .i_reset(reset), .bus(bus));
`endif

    always #5 clock = ~clock;

    // Stimulus schedule and expected per-cycle outputs (cycle c = after posedge c).
    bit  rst_s [MAXC];
    bit  go_s [MAXC];
    bit  done_s [MAXC];
    int  rc_s [MAXC];
    int  to_s [MAXC];
    bit  e_busy [MAXC];
    bit  e_start [MAXC];
    bit  e_valid [MAXC];
    bit  e_done [MAXC];
    bit  e_err [MAXC];
    bit  e_stat [MAXC];
    bit  e_clr [MAXC];
    int  e_rk [MAXC];  // dut_reset: 0 low, 1 high, 2 not checked
    int  e_idx [MAXC];
    int  e_cyc [MAXC];
    int  lat [8];      // done offset in cycles after the start pulse

    function automatic void chk(string name, int c, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
        end
    endfunction

    // Lays out a campaign accepted at cycle g; returns the campaign_done cycle.
    function automatic int plan(int g, int n, int t);
        int s, r, c, fin;
        bit to;
        go_s[g] = 1'b1; rc_s[g] = n; to_s[g] = t; e_clr[g+1] = 1'b1;
        fin = g + 1; to = 1'b0;
        if (n > 0) begin
            s = g + 1 + DRC;
            for (int i = 0; i < n; i++) begin
                c  = lat[i] + 1;
                to = (t != 0) && (c > t);
                if (to) c = t;
                r = s + c;
                e_start[s] = 1'b1;
                for (int k = s; k < r; k++) e_rk[k] = 1;
                if (!to) done_s[s + lat[i]] = 1'b1;
                e_valid[r] = 1'b1; e_idx[r] = i; e_cyc[r] = c; e_stat[r] = to; e_rk[r] = 2;
                if ($urandom_range(0, 1) == 1) done_s[r] = 1'b1;
                fin = r + 1;
                if (to) break;
                s = r + 1 + DRC;
            end
        end
        e_done[fin] = 1'b1; e_err[fin] = to; e_rk[fin] = 2;
        for (int k = g + 1; k <= fin; k++) begin
            e_busy[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) go_s[k] = 1'b1;
        end
        done_s[g+1] = 1'b1;
        return fin;
    endfunction

    // Replays the schedule onto the DUT inputs shortly after each rising edge.
    initial begin
        bus.go = 1'b0; bus.run_count = '0; bus.timeout_cycles = '0; bus.dut_done_port = 1'b0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (cyc < MAXC) begin
                reset              = rst_s[cyc];
                bus.go             = go_s[cyc];
                bus.run_count      = (rc_s[cyc] != 0 || go_s[cyc]) ? RUN_W'(rc_s[cyc])
                                                                    : RUN_W'($urandom);
                bus.timeout_cycles = go_s[cyc] ? CNT_W'(to_s[cyc]) : CNT_W'($urandom);
                bus.dut_done_port  = done_s[cyc];
            end
        end
    end

    // Compare process: every cycle against the planned timeline and held results.
    initial begin
        int h_idx, h_cyc, h_stat;
        longint unsigned h_min, h_max, h_tot;
        h_idx = 0; h_cyc = 0; h_stat = 0; h_min = 0; h_max = 0; h_tot = 0;
        forever begin
            @(negedge clock);
            if (cyc >= 1 && cyc < MAXC) begin
                if (rst_s[cyc-1]) begin
                    h_idx = 0; h_cyc = 0; h_stat = 0; h_min = 0; h_max = 0; h_tot = 0;
                end
                if (e_clr[cyc]) begin
                    h_min = 64'hFFFF_FFFF; h_max = 0; h_tot = 0;
                end
                if (e_valid[cyc]) begin
                    h_idx = e_idx[cyc]; h_cyc = e_cyc[cyc]; h_stat = int'(e_stat[cyc]);
                    if (!e_stat[cyc]) begin
                        if (e_cyc[cyc] < h_min) h_min = e_cyc[cyc];
                        if (e_cyc[cyc] > h_max) h_max = e_cyc[cyc];
                        h_tot += e_cyc[cyc];
                    end
                end
                chk("busy", cyc, 64'(bus.busy), 64'(e_busy[cyc]));
                chk("dut_start_port", cyc, 64'(bus.dut_start_port), 64'(e_start[cyc]));
                chk("run_valid", cyc, 64'(bus.run_valid), 64'(e_valid[cyc]));
                chk("campaign_done", cyc, 64'(bus.campaign_done), 64'(e_done[cyc]));
                chk("campaign_err", cyc, 64'(bus.campaign_err), 64'(e_err[cyc]));
                if (e_rk[cyc] != 2) chk("dut_reset", cyc, 64'(bus.dut_reset), 64'(e_rk[cyc]));
                chk("run_index", cyc, 64'(bus.run_index), 64'(h_idx));
                chk("run_cycles", cyc, 64'(bus.run_cycles), 64'(h_cyc));
                chk("run_status", cyc, 64'(bus.run_status), 64'(h_stat));
`ifdef HLS_RUN_STATS_EN
                chk("min_cycles", cyc, 64'(bus.min_cycles), h_min);
                chk("max_cycles", cyc, 64'(bus.max_cycles), h_max);
                chk("total_cycles", cyc, 64'(bus.total_cycles), h_tot);
`endif
            end
        end
    end

    initial begin
        int g, fin, rc, n, t;
        for (int k = 0; k <= 3; k++) rst_s[k] = 1'b1;
        g = 6;

        // T1: single run, done 10 cycles after start.
        lat[0] = 10;
        fin = plan(g, 1, 0);
        chk("T1 model valid", g, 64'(e_valid[g+14]), 64'd1);
        chk("T1 model run_cycles", g, 64'(e_cyc[g+14]), 64'd11);
        chk("T1 model err", g, 64'(e_err[fin]), 64'd0);
        g = fin + 2;

        // T2: three runs, latencies 5/9/7.
        lat[0] = 5; lat[1] = 9; lat[2] = 7;
        fin = plan(g, 3, 0);
        chk("T2 model run1 cycles", g, 64'(e_cyc[g+22]), 64'd10);
        chk("T2 model run2 start", g, 64'(e_start[g+25]), 64'd1);
        chk("T2 model run2 cycles", g, 64'(e_cyc[g+33]), 64'd8);
        chk("T2 model fin", g, 64'(fin), 64'(g + 34));
        g = fin + 1;

        // T3: run 1 never completes, timeout 20.
        lat[0] = 3; lat[1] = 100; lat[2] = 3; lat[3] = 3;
        fin = plan(g, 4, 20);
        chk("T3 model timeout cycles", g, 64'(e_cyc[g+30]), 64'd20);
        chk("T3 model timeout status", g, 64'(e_stat[g+30]), 64'd1);
        chk("T3 model err", g, 64'(e_err[fin]), 64'd1);
        chk("T3 model fin", g, 64'(fin), 64'(g + 31));
        g = fin + 3;

        // T4: done in the start cycle, then done on the exact timeout cycle.
        lat[0] = 0; lat[1] = 11;
        fin = plan(g, 2, 12);
        chk("T4 model start-cycle done", g, 64'(e_cyc[g+4]), 64'd1);
        chk("T4 model tie cycles", g, 64'(e_cyc[g+19]), 64'd12);
        chk("T4 model tie status", g, 64'(e_stat[g+19]), 64'd0);
        g = fin + 1;

        // T5: zero runs.
        fin = plan(g, 0, 0);
        chk("T5 model fin", g, 64'(fin), 64'(g + 1));
        g = fin + 2;

        // T6: reset during WAIT of run 2, with go held high throughout.
        lat[0] = 2; lat[1] = 3; lat[2] = 40; lat[3] = 5;
        fin = plan(g, 4, 0);
        rc = g + 16 + 6;
        for (int k = g + 1; k <= rc; k++) go_s[k] = 1'b1;
        rst_s[rc] = 1'b1;
        for (int k = rc + 1; k <= fin; k++) begin
            e_busy[k] = 0; e_start[k] = 0; e_valid[k] = 0; e_done[k] = 0; e_err[k] = 0;
            e_stat[k] = 0; e_rk[k] = 0; e_idx[k] = 0; e_cyc[k] = 0; go_s[k] = 0; done_s[k] = 0;
        end
        g = rc + 3;

        // Randomized campaigns, some with timeouts and exact-timeout ties.
        while (g < MAXC - 400) begin
            n = $urandom_range(0, 4);
            t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 40);
            for (int i = 0; i < 8; i++) begin
                lat[i] = $urandom_range(0, 45);
                if (t != 0 && $urandom_range(0, 5) == 0) lat[i] = t - 1;
            end
            fin = plan(g, n, t);
            g = fin + 1 + $urandom_range(0, 3);
        end

        while (cyc < g + 3) @(posedge clock);
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
